// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: FSM states, winner codes, 7-segment table.
package score_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    PAUSE = 2'd1,
    OVER  = 2'd2
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_T1   = 2'b01;
  localparam logic [1:0] WIN_T2   = 2'b10;

  // Active-low segments {g,f,e,d,c,b,a}; element 0 is the digit 0 pattern.
  localparam logic [6:0] SEG7_BLANK = 7'h7F;
  localparam logic [9:0][6:0] SEG7_TABLE = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] seg7_lut(input logic [3:0] digit);
    if (digit > 4'd9) return SEG7_BLANK;
    return SEG7_TABLE[digit];
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Game-controller <-> score keeper signal bundle; seg ports exist only with SCORE_SEVSEG_EN.
interface score_keeper_if;
  logic       team1_score_in;
  logic       team2_score_in;
  logic       new_game;
  logic [3:0] team1_points;
  logic [3:0] team2_points;
  logic       serve_freeze;
  logic       game_over;
  logic [1:0] winner;
`ifdef SCORE_SEVSEG_EN
  logic [6:0] seg_team1;
  logic [6:0] seg_team2;
`endif

  modport master (
    output team1_score_in, team2_score_in, new_game,
    input  team1_points, team2_points, serve_freeze, game_over, winner
`ifdef SCORE_SEVSEG_EN
    , input seg_team1, seg_team2
`endif
  );

  modport slave (
    input  team1_score_in, team2_score_in, new_game,
    output team1_points, team2_points, serve_freeze, game_over, winner
`ifdef SCORE_SEVSEG_EN
    , output seg_team1, seg_team2
`endif
  );
endinterface

// File: rtl/seg7_decoder.sv
// 4-bit binary to active-low 7-segment decode; only present when SCORE_SEVSEG_EN is defined.
`ifdef SCORE_SEVSEG_EN
module seg7_decoder
  import score_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);
  assign seg_o = seg7_lut(digit_i);
endmodule
`endif

// File: rtl/score_keeper.sv
// Point counting, post-goal serve pause and match-end detection for two teams.
// Optional SCORE_SEVSEG_EN adds 7-segment decode of both point counts.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned PAUSE_CYCLES = 50_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  score_keeper_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(PAUSE_CYCLES + 1);
  localparam logic [3:0] WIN_PTS = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PAUSE_CYCLES - 1);

  if (WIN_SCORE == 0 || WIN_SCORE > 9) begin : g_bad_win
    $error("score_keeper: WIN_SCORE must be 1..9");
  end
  if (PAUSE_CYCLES == 0) begin : g_bad_pause
    $error("score_keeper: PAUSE_CYCLES must be >= 1");
  end

  state_e           state_q, state_d;
  logic [3:0]       t1_pts_q, t1_pts_d, t2_pts_q, t2_pts_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       winner_q, winner_d;
  logic             freeze_q, freeze_d, over_q, over_d;
  logic             t1_q, t2_q, ng_q;
  logic             t1_rise, t2_rise, ng_rise;

  assign t1_rise = bus.team1_score_in & ~t1_q;
  assign t2_rise = bus.team2_score_in & ~t2_q;
  assign ng_rise = bus.new_game & ~ng_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= PLAY;
      t1_pts_q <= '0;
      t2_pts_q <= '0;
      cnt_q    <= '0;
      winner_q <= WIN_NONE;
      freeze_q <= 1'b0;
      over_q   <= 1'b0;
      t1_q     <= 1'b0;
      t2_q     <= 1'b0;
      ng_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      t1_pts_q <= t1_pts_d;
      t2_pts_q <= t2_pts_d;
      cnt_q    <= cnt_d;
      winner_q <= winner_d;
      freeze_q <= freeze_d;
      over_q   <= over_d;
      t1_q     <= bus.team1_score_in;
      t2_q     <= bus.team2_score_in;
      ng_q     <= bus.new_game;
    end
  end

  // Next-state: new_game beats everything; simultaneous goals replay the serve
  always_comb begin
    state_d = state_q;
    if (ng_rise) begin
      state_d = PAUSE;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (t1_rise && t2_rise) state_d = PAUSE;
          else if (t1_rise)       state_d = (4'(t1_pts_q + 4'd1) == WIN_PTS) ? OVER : PAUSE;
          else if (t2_rise)       state_d = (4'(t2_pts_q + 4'd1) == WIN_PTS) ? OVER : PAUSE;
        end
        PAUSE:   if (cnt_q == '0) state_d = PLAY;
        OVER:    state_d = OVER;
        default: state_d = PLAY;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    t1_pts_d = t1_pts_q;
    t2_pts_d = t2_pts_q;
    cnt_d    = cnt_q;
    winner_d = winner_q;
    if (ng_rise) begin
      t1_pts_d = '0;
      t2_pts_d = '0;
      winner_d = WIN_NONE;
      cnt_d    = CNT_LOAD;
    end else if (state_q == PLAY) begin
      if (t1_rise && t2_rise) begin
        cnt_d = CNT_LOAD;
      end else if (t1_rise) begin
        t1_pts_d = 4'(t1_pts_q + 4'd1);
        if (t1_pts_d == WIN_PTS) winner_d = WIN_T1;
        else                     cnt_d    = CNT_LOAD;
      end else if (t2_rise) begin
        t2_pts_d = 4'(t2_pts_q + 4'd1);
        if (t2_pts_d == WIN_PTS) winner_d = WIN_T2;
        else                     cnt_d    = CNT_LOAD;
      end
    end else if (state_q == PAUSE && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    freeze_d = (state_d != PLAY);
    over_d   = (state_d == OVER);
  end

  assign bus.team1_points = t1_pts_q;
  assign bus.team2_points = t2_pts_q;
  assign bus.serve_freeze = freeze_q;
  assign bus.game_over    = over_q;
  assign bus.winner       = winner_q;

`ifdef SCORE_SEVSEG_EN
  seg7_decoder u_seg_team1 (.digit_i(t1_pts_q), .seg_o(bus.seg_team1));
  seg7_decoder u_seg_team2 (.digit_i(t2_pts_q), .seg_o(bus.seg_team2));
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper (WIN_SCORE=3, PAUSE_CYCLES=4): driver queues per-cycle expectations, monitor checks.
module tb_score_keeper;

  typedef struct {
    logic [3:0] p1;
    logic [3:0] p2;
    logic       fr;
    logic       ov;
    logic [1:0] w;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  score_keeper_if sk ();

  score_keeper #(.WIN_SCORE(3), .PAUSE_CYCLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sk)
  );

  always #5 clk = ~clk;

`ifdef SCORE_SEVSEG_EN
  function automatic logic [6:0] exp_seg(input logic [3:0] p);
    case (p)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      default: return 7'h7F;
    endcase
  endfunction
`endif

  // Drive one cycle of inputs and queue the outputs expected after that clock edge
  task automatic step(input logic r, input logic a, input logic b, input logic n,
                      input logic [3:0] p1, input logic [3:0] p2, input logic fr,
                      input logic ov, input logic [1:0] w, input string name);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    sk.team1_score_in = a;
    sk.team2_score_in = b;
    sk.new_game = n;
    e.p1 = p1; e.p2 = p2; e.fr = fr; e.ov = ov; e.w = w; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [3:0] p1, input logic [3:0] p2, input logic fr,
                      input logic ov, input logic [1:0] w, input string name);
    step(1'b1, 1'b0, 1'b0, 1'b0, p1, p2, fr, ov, w, name);
  endtask

  // Monitor: compare registered outputs just after each edge that has a queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if (sk.team1_points !== e.p1 || sk.team2_points !== e.p2 ||
            sk.serve_freeze !== e.fr || sk.game_over !== e.ov || sk.winner !== e.w) begin
          bad++;
          $display("FAIL %s: got p1=%0d p2=%0d frz=%b over=%b win=%b, want p1=%0d p2=%0d frz=%b over=%b win=%b",
                   e.name, sk.team1_points, sk.team2_points, sk.serve_freeze, sk.game_over,
                   sk.winner, e.p1, e.p2, e.fr, e.ov, e.w);
        end
`ifdef SCORE_SEVSEG_EN
        total++;
        if (sk.seg_team1 !== exp_seg(e.p1) || sk.seg_team2 !== exp_seg(e.p2)) begin
          bad++;
          $display("FAIL %s_seg: got seg1=%b seg2=%b, want seg1=%b seg2=%b", e.name,
                   sk.seg_team1, sk.seg_team2, exp_seg(e.p1), exp_seg(e.p2));
        end
`endif
      end
    end
  end

  initial begin
    sk.team1_score_in = 1'b0;
    sk.team2_score_in = 1'b0;
    sk.new_game = 1'b0;

    // Reset with toggling inputs, then release
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, "rst_a");
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, "rst_b");
    idle(4'd0, 4'd0, 1'b0, 1'b0, 2'b00, "rst_release");

    // Team1 level held 10 cycles: one point, 4-cycle freeze
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, (i < 4), 1'b0, 2'b00, "t1_hold");
    idle(4'd1, 4'd0, 1'b0, 1'b0, 2'b00, "t1_release");

    // Simultaneous goals: no point, replayed serve pause
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 2'b00, "both_rise");
    for (int i = 0; i < 4; i++)
      idle(4'd1, 4'd0, (i < 3), 1'b0, 2'b00, "both_pause");

    // Fresh reset, then team2 wins 3-0; team1 pulses in OVER ignored
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, "rst_t3");
    for (int g = 1; g <= 3; g++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'(g), 1'b1, (g == 3), (g == 3) ? 2'b10 : 2'b00,
           "t2_goal");
      if (g < 3)
        for (int i = 0; i < 4; i++)
          idle(4'd0, 4'(g), (i < 3), 1'b0, 2'b00, "t2_pause");
    end
    for (int i = 0; i < 4; i++)
      step(1'b1, (i % 2 == 0), 1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 1'b1, 2'b10, "over_hold");

    // new_game in OVER
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 2'b00, "ng_over");
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 2'b00, "ng_held");
    for (int i = 0; i < 3; i++)
      idle(4'd0, 4'd0, (i < 2), 1'b0, 2'b00, "ng_pause");

    // new_game mid-PAUSE with same-cycle goal
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 2'b00, "t1_goal");
    idle(4'd1, 4'd0, 1'b1, 1'b0, 2'b00, "t1_pause");
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 2'b00, "ng_mid_pause");
    for (int i = 0; i < 4; i++)
      idle(4'd0, 4'd0, (i < 3), 1'b0, 2'b00, "ng_mid_pause_cnt");

    // new_game in PLAY with same-cycle goal drops the goal
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 2'b00, "ng_play_goal");
    for (int i = 0; i < 4; i++)
      idle(4'd0, 4'd0, (i < 3), 1'b0, 2'b00, "ng_play_pause");

    // Reset mid-PAUSE returns to PLAY immediately
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 2'b00, "t2_goal_b");
    idle(4'd0, 4'd1, 1'b1, 1'b0, 2'b00, "t2_pause_b");
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, "rst_mid_pause");
    idle(4'd0, 4'd0, 1'b0, 1'b0, 2'b00, "play_after_rst");
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 2'b00, "t1_after_rst");
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 2'b00, "t1_after_rst_hold");

    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
